// File: rtl/lab3_sweep_pkg.sv
// rtl/lab3_sweep_pkg.sv - shared state encoding and constants for the lab3 sweep sequencer
package lab3_sweep_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  // x^16 + x^12 + x^5 + 1, top term implicit
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // Default truth tables for the 3-input unit: x = parity(a,b,c), y = majority(a,b,c)
  localparam logic [7:0] EXP_X_DEF = 8'h96;
  localparam logic [7:0] EXP_Y_DEF = 8'hE8;

endpackage

// File: rtl/lab3_sweep_misr.sv
// rtl/lab3_sweep_misr.sv - 16-bit MISR compacting captured {x,y} pairs
module lab3_sweep_misr
  import lab3_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [1:0]  i_data,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;
  logic [15:0] w_fb;

  assign w_fb  = r_sig[15] ? MISR_POLY : 16'h0000;
  assign o_sig = r_sig;

  // Clear on a new sweep, otherwise shift one step and fold in the captured pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 16'h0000;
    end else if (i_clr) begin
      r_sig <= 16'h0000;
    end else if (i_shift) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ w_fb ^ {14'h0000, i_data};
    end
  end

endmodule

// File: rtl/lab3_sweep_ctrl.sv
// rtl/lab3_sweep_ctrl.sv - self-test sweep sequencer for the lab3 unit; LAB3_SWEEP_SIGNATURE_EN adds a MISR signature port
module lab3_sweep_ctrl
  import lab3_sweep_pkg::*;
#(
  parameter int                 N_IN   = 3,
  parameter int                 SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXP_X  = EXP_X_DEF,
  parameter logic [2**N_IN-1:0] EXP_Y  = EXP_Y_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            x_in,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_idx
`ifdef LAB3_SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]     signature
`endif
);

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;
  localparam logic [N_IN-1:0] IDX_ONE   = {{(N_IN-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [N_IN-1:0] r_idx;
  logic [3:0]      r_cnt;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err;
  logic            r_ff_vld;
  logic [N_IN-1:0] r_ff_idx;

  logic            w_mis;
  logic [N_IN:0]   w_err_next;

  // Outputs come straight from the unit under vec_out, which is registered, so this is clean
  assign w_mis      = (x_in != EXP_X[r_idx]) || (y_in != EXP_Y[r_idx]);
  assign w_err_next = r_err + {{N_IN{1'b0}}, w_mis};

  assign vec_out        = r_vec;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_idx = r_ff_idx;

  // Sweep FSM: abort beats everything outside IDLE; results hold until the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= 4'd0;
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ff_vld <= 1'b0;
      r_ff_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_pass  <= 1'b0;
        r_vec   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_err    <= '0;
              r_ff_vld <= 1'b0;
              r_ff_idx <= '0;
              r_pass   <= 1'b0;
              r_idx    <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            r_vec   <= r_idx;
            r_cnt   <= SETTLE_LD;
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_cnt == 4'd0) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          ST_CAPTURE: begin
            r_err <= w_err_next;
            if (w_mis && !r_ff_vld) begin
              r_ff_vld <= 1'b1;
              r_ff_idx <= r_idx;
            end
            if (r_idx == IDX_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_err_next == '0);
              r_state <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_state <= ST_DRIVE;
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LAB3_SWEEP_SIGNATURE_EN
  logic w_accept;
  logic w_capture;

  assign w_accept  = (r_state == ST_IDLE) && start && !abort;
  assign w_capture = (r_state == ST_CAPTURE) && !abort;

  lab3_sweep_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_shift(w_capture),
    .i_data ({x_in, y_in}),
    .o_sig  (signature)
  );
`endif

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// tb/tb_lab3_sweep_ctrl.sv - self-checking bench for lab3_sweep_ctrl
module tb_lab3_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [2:0] vec_out;
  logic       x_in;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic       first_fail_vld;
  logic [2:0] first_fail_idx;
`ifdef LAB3_SWEEP_SIGNATURE_EN
  logic [15:0] signature;
  logic [15:0] sig_prev;
`endif

  // Fault injection masks: bit v flips the unit's x/y output for vector v
  logic [7:0] xmask;
  logic [7:0] ymask;

  int n_checks;
  int n_errors;

  lab3_sweep_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .vec_out       (vec_out),
    .x_in          (x_in),
    .y_in          (y_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx)
`ifdef LAB3_SWEEP_SIGNATURE_EN
    ,
    .signature     (signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj3(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // Unit model: x = parity, y = majority, with optional per-vector faults
  always_comb begin
    x_in = (^vec_out) ^ xmask[vec_out];
    y_in = maj3(vec_out) ^ ymask[vec_out];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference results from the fault masks: any flipped bit is a failing vector
  task automatic ref_model(output int e_err, output int e_vld, output int e_idx, output int e_pass);
    logic [7:0] bad;
    bad   = xmask | ymask;
    e_err = $countones(bad);
    e_vld = (bad != 8'h00) ? 1 : 0;
    e_idx = 0;
    for (int v = 7; v >= 0; v--) if (bad[v]) e_idx = v;
    e_pass = (bad == 8'h00) ? 1 : 0;
  endtask

  function automatic logic [15:0] ref_sig();
    logic [15:0] s;
    logic [2:0]  v;
    s = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000)
          ^ {14'h0000, (^v) ^ xmask[i], maj3(v) ^ ymask[i]};
    end
    return s;
  endfunction

  // Pulse start, optionally re-pulse it mid-sweep, and time the done pulse
  task automatic run_sweep(input int restart_at, output int cyc);
    logic vec_ok;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc    = 1;
    vec_ok = 1'b1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      if (cyc >= 2 && cyc <= 30 && ((cyc - 2) % 4) == 0)
        if (vec_out != 3'((cyc - 2) / 4)) vec_ok = 1'b0;
      start = (cyc == restart_at);
      @(posedge clk); #1 cyc++;
    end
    start = 1'b0;
    chk("done_latency", 32'(cyc), 32'd33);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("vec_steps", 32'(vec_ok), 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic check_results(input string tag);
    int e_err, e_vld, e_idx, e_pass;
    ref_model(e_err, e_vld, e_idx, e_pass);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e_err));
    chk({tag, "_ff_vld"}, 32'(first_fail_vld), 32'(e_vld));
    chk({tag, "_ff_idx"}, 32'(first_fail_idx), 32'(e_idx));
    chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
`ifdef LAB3_SWEEP_SIGNATURE_EN
    chk({tag, "_signature"}, 32'(signature), 32'(ref_sig()));
`endif
  endtask

  typedef struct {
    logic [7:0] xm;
    logic [7:0] ym;
    int         err;
    int         vld;
    int         idx;
    int         ps;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int cyc;
    int seen;
    n_checks = 0;
    n_errors = 0;
    start = 1'b0;
    abort = 1'b0;
    xmask = 8'h00;
    ymask = 8'h00;
    rst_n = 1'b0;

    tbl[0] = '{8'h00, 8'h00, 0, 0, 0, 1};
    tbl[1] = '{8'h00, 8'hE8, 4, 1, 3, 0};
    tbl[2] = '{8'h20, 8'h00, 1, 1, 5, 0};
    tbl[3] = '{8'hFF, 8'h00, 8, 1, 0, 0};
    tbl[4] = '{8'h80, 8'h80, 1, 1, 7, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_vec", 32'(vec_out), 32'd0);
    chk("rst_ffv", 32'(first_fail_vld), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'd0);
    rst_n = 1'b1;

    // Directed table: clean, y stuck low, single x fault, all failing, last vector only
    for (int i = 0; i < 5; i++) begin
      xmask = tbl[i].xm;
      ymask = tbl[i].ym;
      run_sweep(-1, cyc);
      chk("tbl_err", 32'(err_cnt), 32'(tbl[i].err));
      chk("tbl_ffv", 32'(first_fail_vld), 32'(tbl[i].vld));
      chk("tbl_ffi", 32'(first_fail_idx), 32'(tbl[i].idx));
      chk("tbl_pass", 32'(pass), 32'(tbl[i].ps));
    end

    // Random fault patterns against the reference model
    for (int i = 0; i < 8; i++) begin
      xmask = 8'($urandom);
      ymask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      run_sweep(-1, cyc);
      check_results("rnd");
    end

    // Clean sweep then abort 10 cycles into the next one
    xmask = 8'h00;
    ymask = 8'h00;
    run_sweep(-1, cyc);
    chk("pre_abort_pass", 32'(pass), 32'd1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_vec", 32'(vec_out), 32'd0);
    abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_sweep(-1, cyc);
    check_results("post_abort");

    // Start pulsed while busy must not change timing or results
    run_sweep(5, cyc);
    check_results("restart_ignored");
`ifdef LAB3_SWEEP_SIGNATURE_EN
    sig_prev = signature;
    run_sweep(-1, cyc);
    chk("sig_repeat", 32'(signature), 32'(sig_prev));
`endif

    // Asynchronous reset mid-sweep with a partial error count
    ymask = 8'hE8;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_rst_err", 32'(err_cnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_cnt), 32'd0);
    chk("arst_ffv", 32'(first_fail_vld), 32'd0);
    chk("arst_ffi", 32'(first_fail_idx), 32'd0);
    chk("arst_vec", 32'(vec_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ymask = 8'h00;
    run_sweep(-1, cyc);
    check_results("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
